booth_r4_seq_mul: RTL and testbench

- Iterative signed radix-4 Booth multiplier core: DATA_W x DATA_W -> 2*DATA_W, two's complement.
- Scans the multiplier two bits per cycle and forms Booth triplets.
- Drives the existing mul_comp partial-product stage and accumulates its sign-extended, shifted output.
- Sits between the operand source (valid/ready) and the product consumer (valid/ready).

---
 rtl/booth_pkg.sv | 22 ++
 rtl/mul_comp.sv | 27 ++
 rtl/booth_r4_seq_mul.sv | 114 +++++++++++
 tb/tb_booth_r4_seq_mul.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-4 Booth sequential multiplier.
// Booth code values here must stay in step with mul_comp's decode.
package booth_pkg;

    localparam int unsigned DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    localparam logic [2:0] CODE_Z0  = 3'b000;
    localparam logic [2:0] CODE_P1A = 3'b001;
    localparam logic [2:0] CODE_P1B = 3'b010;
    localparam logic [2:0] CODE_P2  = 3'b011;
    localparam logic [2:0] CODE_M2  = 3'b100;
    localparam logic [2:0] CODE_M1A = 3'b101;
    localparam logic [2:0] CODE_M1B = 3'b110;
    localparam logic [2:0] CODE_Z1  = 3'b111;

endpackage

// File: rtl/mul_comp.sv
// Radix-4 Booth partial-product generator: 8-bit signed multiplicand times a
// Booth code in {-2,-1,0,+1,+2}, delivered as a 10-bit signed value.
module mul_comp
    import booth_pkg::*;
(
    input  logic [7:0] data_i,
    input  logic [2:0] multi_i,
    output logic [9:0] pp_o
);

    logic [9:0] data_ext;

    // Two guard bits so that -2 * -128 = +256 still fits.
    assign data_ext = {{2{data_i[7]}}, data_i};

    always_comb begin
        pp_o = '0;
        case (multi_i)
            CODE_P1A, CODE_P1B: pp_o = data_ext;
            CODE_P2:            pp_o = data_ext << 1;
            CODE_M2:            pp_o = -(data_ext << 1);
            CODE_M1A, CODE_M1B: pp_o = -data_ext;
            default:            pp_o = '0;
        endcase
    end

endmodule

// File: rtl/booth_r4_seq_mul.sv
// Iterative signed radix-4 Booth multiplier with valid/ready on both sides.
// Optional BOOTH_EARLY_TERM_EN stops as soon as the remaining Booth codes are all zero.
module booth_r4_seq_mul
    import booth_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned PP_W   = DATA_W + 2,
    parameter int unsigned PROD_W = 2 * DATA_W,
    parameter int unsigned ITER   = DATA_W / 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] mcand_i,
    input  logic [DATA_W-1:0] mplier_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [PROD_W-1:0] product_o
);

    localparam int unsigned CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  mcand_q, mcand_d;
    logic [DATA_W:0]    scan_q, scan_d;
    logic [PROD_W-1:0]  acc_q, acc_d;
    logic [PROD_W-1:0]  prod_q, prod_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [PP_W-1:0]    pp;
    logic [PROD_W-1:0]  pp_shifted;
    logic [DATA_W:0]    scan_shift;
    logic               last_iter;
    logic               finish;

    mul_comp u_mul_comp (
        .data_i  (mcand_q),
        .multi_i (scan_q[2:0]),
        .pp_o    (pp)
    );

    assign pp_shifted = {{(PROD_W - PP_W){pp[PP_W-1]}}, pp} << {cnt_q, 1'b0};
    assign scan_shift = {{2{scan_q[DATA_W]}}, scan_q[DATA_W:2]};
    assign last_iter  = (cnt_q == CNT_W'(ITER - 1));

`ifdef BOOTH_EARLY_TERM_EN
    // A scan register of all-equal bits can only yield zero codes from here on.
    assign finish = last_iter || (scan_shift == '0) || (scan_shift == '1);
`else
    assign finish = last_iter;
`endif

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        scan_d  = scan_q;
        acc_d   = acc_q;
        prod_d  = prod_q;
        cnt_d   = cnt_q;
        ready_o = 1'b0;
        valid_o = 1'b0;

        case (state_q)
            IDLE: begin
                ready_o = 1'b1;
                if (valid_i) begin
                    mcand_d = mcand_i;
                    scan_d  = {mplier_i, 1'b0};
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d  = acc_q + pp_shifted;
                scan_d = scan_shift;
                cnt_d  = cnt_q + 1'b1;
                if (finish) begin
                    prod_d  = acc_d;
                    state_d = DONE;
                end
            end
            DONE: begin
                valid_o = 1'b1;
                if (ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            mcand_q <= '0;
            scan_q  <= '0;
            acc_q   <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            scan_q  <= scan_d;
            acc_q   <= acc_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
        end
    end

    assign product_o = prod_q;

endmodule

// File: tb/tb_booth_r4_seq_mul.sv
// Self-checking bench for booth_r4_seq_mul: directed corners, random operands
// against an arithmetic reference, DONE back-pressure, back-to-back and mid-run reset.
module tb_booth_r4_seq_mul;

    localparam int ITER = 4;

    logic        clk;
    logic        rst_ni;
    logic        valid_i;
    logic        ready_o;
    logic [7:0]  mcand_i;
    logic [7:0]  mplier_i;
    logic        valid_o;
    logic        ready_i;
    logic [15:0] product_o;

    int n_checks;
    int n_pass;

    booth_r4_seq_mul dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .mcand_i   (mcand_i),
        .mplier_i  (mplier_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .product_o (product_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        return p[15:0];
    endfunction

    // Edges from the handshake edge to the one after which valid_o is seen high.
    function automatic int exp_lat(input logic [7:0] m);
        int sm;
        sm = int'($signed(m));
`ifdef BOOTH_EARLY_TERM_EN
        for (int k = 1; k <= ITER; k++) begin
            int t;
            t = sm >>> (2 * k - 1);
            if (t == 0 || t == -1) return k;
        end
`endif
        if (sm == 12345) return 0;
        return ITER;
    endfunction

    // One full transaction from IDLE; returns the product and measured latency.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                         output logic [15:0] prod, output int lat);
        int n;
        valid_i  = 1'b1;
        mcand_i  = a;
        mplier_i = b;
        @(posedge clk); #1;
        valid_i = 1'b0;
        n = 0;
        while (!valid_o && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        prod    = product_o;
        lat     = n;
        ready_i = 1'b1;
        @(posedge clk); #1;
        ready_i = 1'b0;
    endtask

    task automatic test_reset;
        rst_ni   = 1'b0;
        valid_i  = 1'b0;
        ready_i  = 1'b0;
        mcand_i  = '0;
        mplier_i = '0;
        #2;
        n_checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0 || product_o !== 16'h0000)
            $display("FAIL reset: ready_o=%b valid_o=%b product_o=%h, required 1 0 0000",
                     ready_o, valid_o, product_o);
        else n_pass++;
        @(posedge clk); @(posedge clk); #1;
        rst_ni = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_corners;
        logic [7:0]  ta [6];
        logic [7:0]  tb [6];
        logic [15:0] te [6];
        logic [15:0] p;
        int          lat;
        ta = '{8'd7,   8'h80, 8'h7F, 8'hFF, 8'h00, 8'h55};
        tb = '{8'd3,   8'h80, 8'h80, 8'hFF, 8'h55, 8'h00};
        te = '{16'h0015, 16'h4000, 16'hC080, 16'h0001, 16'h0000, 16'h0000};
        for (int i = 0; i < 6; i++) begin
            do_op(ta[i], tb[i], p, lat);
            n_checks++;
            if (p !== te[i])
                $display("FAIL corner_product %h*%h: got %h required %h", ta[i], tb[i], p, te[i]);
            else n_pass++;
            n_checks++;
            if (lat !== exp_lat(tb[i]))
                $display("FAIL corner_latency %h*%h: got %0d required %0d",
                         ta[i], tb[i], lat, exp_lat(tb[i]));
            else n_pass++;
        end
    endtask

    task automatic test_random;
        logic [7:0]  a, b;
        logic [15:0] p;
        int          lat;
        for (int i = 0; i < 1500; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            do_op(a, b, p, lat);
            n_checks++;
            if (p !== ref_mul(a, b))
                $display("FAIL random_product %h*%h: got %h required %h", a, b, p, ref_mul(a, b));
            else n_pass++;
            n_checks++;
            if (lat !== exp_lat(b))
                $display("FAIL random_latency %h*%h: got %0d required %0d", a, b, lat, exp_lat(b));
            else n_pass++;
        end
    endtask

    task automatic test_early_term;
        logic [15:0] p;
        int          lat;
        do_op(8'd9, 8'd1, p, lat);
        n_checks++;
        if (p !== 16'h0009) $display("FAIL et_9x1_product: got %h required 0009", p);
        else n_pass++;
        n_checks++;
`ifdef BOOTH_EARLY_TERM_EN
        if (lat !== 1) $display("FAIL et_9x1_latency: got %0d required 1", lat);
`else
        if (lat !== ITER) $display("FAIL et_9x1_latency: got %0d required %0d", lat, ITER);
`endif
        else n_pass++;
        do_op(8'd9, 8'h40, p, lat);
        n_checks++;
        if (p !== 16'h0240) $display("FAIL et_9x40_product: got %h required 0240", p);
        else n_pass++;
        n_checks++;
        if (lat !== ITER) $display("FAIL et_9x40_latency: got %0d required %0d", lat, ITER);
        else n_pass++;
    endtask

    task automatic test_hold;
        logic [7:0]  a, b;
        logic [15:0] e;
        int          n;
        a = 8'($urandom_range(1, 127));
        b = 8'h93;
        e = ref_mul(a, b);
        valid_i  = 1'b1;
        mcand_i  = a;
        mplier_i = b;
        @(posedge clk); #1;
        mcand_i  = ~a;
        mplier_i = ~b;
        n = 0;
        while (!valid_o && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        n_checks++;
        if (n !== exp_lat(b)) $display("FAIL hold_latency: got %0d required %0d", n, exp_lat(b));
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (valid_o !== 1'b1 || ready_o !== 1'b0 || product_o !== e)
                $display("FAIL hold_cycle%0d: valid_o=%b ready_o=%b product_o=%h, required 1 0 %h",
                         i, valid_o, ready_o, product_o, e);
            else n_pass++;
            @(posedge clk); #1;
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(posedge clk); #1;
        ready_i = 1'b0;
        n_checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0)
            $display("FAIL hold_release: ready_o=%b valid_o=%b, required 1 0", ready_o, valid_o);
        else n_pass++;
    endtask

    // valid_i and ready_i stay high: each op should take its latency plus two edges.
    task automatic test_back_to_back;
        logic [7:0] a [4];
        logic [7:0] b [4];
        int         n;
        for (int i = 0; i < 4; i++) begin
            a[i] = 8'($urandom);
            b[i] = 8'($urandom);
        end
        ready_i  = 1'b1;
        valid_i  = 1'b1;
        mcand_i  = a[0];
        mplier_i = b[0];
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (i < 3) begin
                mcand_i  = a[i+1];
                mplier_i = b[i+1];
            end
            n = 0;
            while (!valid_o && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            n_checks++;
            if (product_o !== ref_mul(a[i], b[i]) || n !== exp_lat(b[i]))
                $display("FAIL b2b_op%0d: product_o=%h latency=%0d, required %h %0d",
                         i, product_o, n, ref_mul(a[i], b[i]), exp_lat(b[i]));
            else n_pass++;
            @(posedge clk); #1;
            n_checks++;
            if (ready_o !== 1'b1 || valid_o !== 1'b0)
                $display("FAIL b2b_idle%0d: ready_o=%b valid_o=%b, required 1 0",
                         i, ready_o, valid_o);
            else n_pass++;
        end
        valid_i = 1'b0;
        ready_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_run;
        logic [15:0] p;
        int          lat;
        int          pulses;
        valid_i  = 1'b1;
        mcand_i  = 8'h7F;
        mplier_i = 8'h55;
        @(posedge clk); #1;
        valid_i = 1'b0;
        @(posedge clk); #2;
        rst_ni = 1'b0;
        #1;
        n_checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0 || product_o !== 16'h0000)
            $display("FAIL midrun_reset: ready_o=%b valid_o=%b product_o=%h, required 1 0 0000",
                     ready_o, valid_o, product_o);
        else n_pass++;
        @(posedge clk); @(posedge clk); #1;
        rst_ni = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (valid_o) pulses++;
        end
        n_checks++;
        if (pulses !== 0) $display("FAIL midrun_no_valid: got %0d pulses required 0", pulses);
        else n_pass++;
        do_op(8'd5, 8'd5, p, lat);
        n_checks++;
        if (p !== 16'h0019) $display("FAIL midrun_next_op: got %h required 0019", p);
        else n_pass++;
        n_checks++;
        if (lat !== exp_lat(8'd5))
            $display("FAIL midrun_next_latency: got %0d required %0d", lat, exp_lat(8'd5));
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_corners();
        test_early_term();
        test_random();
        test_hold();
        test_back_to_back();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
